// File: rtl/alu_ctrl_decoder_if.sv
// Instruction handshake, registered ALU controls and flag loop between the decoder and its ALU.
// The decoder is the slave; the instruction source and ALU model together form the master.
interface alu_ctrl_decoder_if #(
   parameter int IW = 16
);
   logic [IW-1:0] instr_pi;
   logic          instr_valid_pi;
   logic          instr_ready_po;
   logic          ctrl_valid_po;
   logic          arith_2op_po;
   logic          arith_1op_po;
   logic [2:0]    alu_func_po;
   logic          addi_po;
   logic          subi_po;
   logic          load_or_store_po;
   logic [5:0]    immediate_po;
   logic          stc_cmd_po;
   logic          stb_cmd_po;
   logic          carry_in_po;
   logic          borrow_in_po;
   logic          carry_out_pi;
   logic          borrow_out_pi;
   logic          halted_po;
   logic          illegal_po;

   modport slave (
      input  instr_pi, instr_valid_pi, carry_out_pi, borrow_out_pi,
      output instr_ready_po, ctrl_valid_po, arith_2op_po, arith_1op_po, alu_func_po,
             addi_po, subi_po, load_or_store_po, immediate_po, stc_cmd_po, stb_cmd_po,
             carry_in_po, borrow_in_po, halted_po, illegal_po
   );

   modport master (
      output instr_pi, instr_valid_pi, carry_out_pi, borrow_out_pi,
      input  instr_ready_po, ctrl_valid_po, arith_2op_po, arith_1op_po, alu_func_po,
             addi_po, subi_po, load_or_store_po, immediate_po, stc_cmd_po, stb_cmd_po,
             carry_in_po, borrow_in_po, halted_po, illegal_po
   );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// Decode stage: registers one-hot ALU controls per accepted instruction and owns carry/borrow flags.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN turns undefined encodings into a sticky illegal trap + HALT.
module alu_ctrl_decoder #(
   parameter int IW = 16
) (
   input  logic              clk_pi,
   input  logic              reset_pi,
   alu_ctrl_decoder_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

   typedef struct packed {
      logic       vld;
      logic       arith_2op;
      logic       arith_1op;
      logic [2:0] func;
      logic       addi;
      logic       subi;
      logic       ls;
      logic [5:0] imm;
      logic       stc;
      logic       stb;
      logic       rst_cmd;
      logic       halt;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      logic       vld;
      logic       arith_2op;
      logic       arith_1op;
      logic [2:0] func;
      logic       addi;
      logic       subi;
      logic       ls;
      logic [5:0] imm;
      logic       stc;
      logic       stb;
      logic       rst_cmd;
   } ctl_t;

   function automatic dec_t decode(input logic [IW-1:0] ins);
      dec_t       d;
      logic [3:0] op;
      logic [11:0] cmd;
      d       = '0;
      op      = ins[15:12];
      cmd     = ins[11:0];
      d.vld   = 1'b1;
      case (op)
         4'h1: begin
            d.arith_2op = 1'b1;
            d.func      = ins[2:0];
         end
         4'h2: begin
            d.arith_1op = 1'b1;
            d.func      = ins[2:0];
         end
         4'h3: d.imm = ins[5:0];
         4'h4: begin
            d.addi = 1'b1;
            d.imm  = ins[5:0];
         end
         4'h5: begin
            d.subi = 1'b1;
            d.imm  = ins[5:0];
         end
         4'h6, 4'h7: begin
            d.ls  = 1'b1;
            d.imm = ins[5:0];
         end
         4'hD, 4'hE: d.illegal = 1'b1;
         4'hF: begin
            case (cmd)
               12'h001: d.stc     = 1'b1;
               12'h002: d.stb     = 1'b1;
               12'hAAA: d.rst_cmd = 1'b1;
               12'hFFF: d.halt    = 1'b1;
               default: d.illegal = 1'b1;
            endcase
         end
         default: ;
      endcase
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      if (d.illegal) d.vld = 1'b0;
`else
      d.illegal = 1'b0;
`endif
      return d;
   endfunction

   function automatic ctl_t to_ctl(input dec_t d);
      ctl_t c;
      c.vld       = d.vld;
      c.arith_2op = d.arith_2op;
      c.arith_1op = d.arith_1op;
      c.func      = d.func;
      c.addi      = d.addi;
      c.subi      = d.subi;
      c.ls        = d.ls;
      c.imm       = d.imm;
      c.stc       = d.stc;
      c.stb       = d.stb;
      c.rst_cmd   = d.rst_cmd;
      return c;
   endfunction

   state_t r_state;
   state_t w_state_nxt;
   dec_t   w_dec;
   logic   w_ready;
   logic   w_xfer;
   ctl_t   r_ctl_p1;
   logic   r_carry;
   logic   r_borrow;

   assign w_dec   = decode(bus.instr_pi);
   assign w_ready = (r_state == ST_RUN);
   assign w_xfer  = bus.instr_valid_pi & w_ready;

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = ST_RUN;
         ST_RUN:  if (w_xfer && (w_dec.halt || w_dec.illegal)) w_state_nxt = ST_HALT;
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Stage p1: controls live for exactly one cycle after the accepting edge
   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi)    r_ctl_p1 <= '0;
      else if (w_xfer) r_ctl_p1 <= to_ctl(w_dec);
      else             r_ctl_p1 <= '0;
   end

   // Flag capture closes the loop through the ALU at the edge ending the p1 cycle
   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else if (r_ctl_p1.vld) begin
         if (r_ctl_p1.rst_cmd) begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
         end else begin
            r_carry  <= bus.carry_out_pi;
            r_borrow <= bus.borrow_out_pi;
         end
      end
   end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi)                       r_illegal <= 1'b0;
      else if (w_xfer && w_dec.illegal)   r_illegal <= 1'b1;
   end

   assign bus.illegal_po = r_illegal;
`else
   assign bus.illegal_po = 1'b0;
`endif

   assign bus.instr_ready_po   = w_ready;
   assign bus.ctrl_valid_po    = r_ctl_p1.vld;
   assign bus.arith_2op_po     = r_ctl_p1.arith_2op;
   assign bus.arith_1op_po     = r_ctl_p1.arith_1op;
   assign bus.alu_func_po      = r_ctl_p1.func;
   assign bus.addi_po          = r_ctl_p1.addi;
   assign bus.subi_po          = r_ctl_p1.subi;
   assign bus.load_or_store_po = r_ctl_p1.ls;
   assign bus.immediate_po     = r_ctl_p1.imm;
   assign bus.stc_cmd_po       = r_ctl_p1.stc;
   assign bus.stb_cmd_po       = r_ctl_p1.stb;
   assign bus.carry_in_po      = r_carry;
   assign bus.borrow_in_po     = r_borrow;
   assign bus.halted_po        = (r_state == ST_HALT);

endmodule
